// File: rtl/eoi_priority_control_8259a.sv
// 8259A end-of-interrupt / priority-rotation command driver: decodes OCW2 and AEOI events.
// Optional AEOI support is compiled in when EOI_CTRL_AUTO_EOI_EN is defined.
module eoi_priority_control_8259a (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_initial_command_word_1,
  input  logic       write_operation_control_word_2,
  input  logic [7:0] internal_data_bus,
  input  logic [7:0] highest_level_in_service,
  input  logic       auto_eoi_config,
  input  logic       end_of_acknowledge_sequence,
  input  logic [7:0] acknowledge_level,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic       auto_rotate_mode
);

  logic [7:0] eoi_q, eoi_d;
  logic [2:0] rot_q, rot_d;
  logic       arm_q, arm_d;
  logic [2:0] level;
  logic       ocw_rotated;

  // Position of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign level = internal_data_bus[2:0];

`ifndef EOI_CTRL_AUTO_EOI_EN
  logic unused_aeoi;
  assign unused_aeoi = ^{auto_eoi_config, end_of_acknowledge_sequence, acknowledge_level};
`endif
  logic unused_bus;
  assign unused_bus = ^internal_data_bus[4:3];

  always_comb begin
    eoi_d       = '0;
    rot_d       = rot_q;
    arm_d       = arm_q;
    ocw_rotated = 1'b0;
    if (write_operation_control_word_2) begin
      case (internal_data_bus[7:5])
        3'b001: eoi_d = highest_level_in_service;
        3'b011: eoi_d = 8'd1 << level;
        3'b101: begin
          eoi_d = highest_level_in_service;
          if (highest_level_in_service != 8'h00) begin
            rot_d       = lowest_idx(highest_level_in_service);
            ocw_rotated = 1'b1;
          end
        end
        3'b111: begin
          eoi_d       = 8'd1 << level;
          rot_d       = level;
          ocw_rotated = 1'b1;
        end
        3'b110: begin
          rot_d       = level;
          ocw_rotated = 1'b1;
        end
`ifdef EOI_CTRL_AUTO_EOI_EN
        3'b100: arm_d = 1'b1;
        3'b000: arm_d = 1'b0;
`endif
        default: ;
      endcase
    end
`ifdef EOI_CTRL_AUTO_EOI_EN
    // AEOI uses the rotate mode already in effect, not one written this cycle.
    if (auto_eoi_config && end_of_acknowledge_sequence) begin
      eoi_d = eoi_d | acknowledge_level;
      if (arm_q && acknowledge_level != 8'h00 && !ocw_rotated)
        rot_d = lowest_idx(acknowledge_level);
    end
`endif
    if (write_initial_command_word_1) begin
      eoi_d = '0;
      rot_d = 3'b111;
      arm_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eoi_q <= '0;
      rot_q <= 3'b111;
      arm_q <= 1'b0;
    end else begin
      eoi_q <= eoi_d;
      rot_q <= rot_d;
      arm_q <= arm_d;
    end
  end

  assign end_of_interrupt = eoi_q;
  assign priority_rotate  = rot_q;
  assign auto_rotate_mode = arm_q;

endmodule

// File: tb/tb_eoi_priority_control_8259a.sv
// Self-checking bench for eoi_priority_control_8259a: directed cases plus randomized traffic
// against a behavioural model (follows EOI_CTRL_AUTO_EOI_EN like the design).
module tb_eoi_priority_control_8259a;

  logic       clock = 1'b0;
  logic       reset, icw1, ocw2, cfg, eoas;
  logic [7:0] bus, hlis, ack;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic       auto_rotate_mode;

  int errors = 0;
  int checks = 0;

  // Model state: values the outputs must show after the most recent edge.
  logic [7:0] m_eoi;
  logic [2:0] m_rot;
  logic       m_arm;

  always #5 clock = ~clock;

  eoi_priority_control_8259a dut (
    .clock                          (clock),
    .reset                          (reset),
    .write_initial_command_word_1   (icw1),
    .write_operation_control_word_2 (ocw2),
    .internal_data_bus              (bus),
    .highest_level_in_service       (hlis),
    .auto_eoi_config                (cfg),
    .end_of_acknowledge_sequence    (eoas),
    .acknowledge_level              (ack),
    .end_of_interrupt               (end_of_interrupt),
    .priority_rotate                (priority_rotate),
    .auto_rotate_mode               (auto_rotate_mode)
  );

  // Lowest set bit via two's-complement isolation, then log2 of the power of two.
  function automatic logic [2:0] low_bit(input logic [7:0] x);
    logic [7:0] iso;
    iso = x & (8'(~x) + 8'd1);
    return 3'($clog2(iso));
  endfunction

  task automatic model_step();
    logic       r, sl, e, rotated, next_arm;
    logic [2:0] l;
    logic [7:0] mask;
    if (reset || icw1) begin
      m_eoi = 8'h00; m_rot = 3'b111; m_arm = 1'b0;
      return;
    end
    mask = 8'h00; rotated = 1'b0; next_arm = m_arm;
    if (ocw2) begin
      r = bus[7]; sl = bus[6]; e = bus[5]; l = bus[2:0];
      if (e) mask = sl ? (8'h01 << l) : hlis;
      if (r && sl) begin
        m_rot = l; rotated = 1'b1;
      end else if (r && e && hlis != 8'h00) begin
        m_rot = low_bit(hlis); rotated = 1'b1;
      end
`ifdef EOI_CTRL_AUTO_EOI_EN
      if (!sl && !e) next_arm = r;
`endif
    end
`ifdef EOI_CTRL_AUTO_EOI_EN
    if (cfg && eoas) begin
      mask = mask | ack;
      if (m_arm && ack != 8'h00 && !rotated) m_rot = low_bit(ack);
    end
`endif
    m_eoi = mask;
    m_arm = next_arm;
  endtask

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Advance one clock: model the edge, then compare all outputs on the falling edge.
  task automatic tick();
    model_step();
    @(negedge clock);
    cmp("eoi", end_of_interrupt, m_eoi);
    cmp("rot", {5'd0, priority_rotate}, {5'd0, m_rot});
    cmp("arm", {7'd0, auto_rotate_mode}, {7'd0, m_arm});
  endtask

  task automatic idle();
    reset = 0; icw1 = 0; ocw2 = 0; eoas = 0; ack = 8'h00;
  endtask

  task automatic ocw(input logic [7:0] d, input logic [7:0] h);
    idle(); ocw2 = 1; bus = d; hlis = h;
    tick();
    ocw2 = 0;
  endtask

  initial begin
    reset = 1; icw1 = 0; ocw2 = 0; cfg = 0; eoas = 0;
    bus = 8'h00; hlis = 8'h00; ack = 8'h00;
    m_eoi = 8'h00; m_rot = 3'b111; m_arm = 1'b0;
    tick(); tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    cmp("rst_eoi", end_of_interrupt, 8'h00);
    cmp("rst_rot", {5'd0, priority_rotate}, 8'h07);
    cmp("rst_arm", {7'd0, auto_rotate_mode}, 8'h00);

    ocw(8'h20, 8'h08);
    cmp("nsEOI_mask", end_of_interrupt, 8'h08);
    cmp("nsEOI_rot", {5'd0, priority_rotate}, 8'h07);
    tick();
    cmp("pulse_end", end_of_interrupt, 8'h00);
    ocw(8'h20, 8'h00);
    cmp("nsEOI_empty", end_of_interrupt, 8'h00);

    ocw(8'hE5, 8'h00);
    cmp("rsEOI_mask", end_of_interrupt, 8'h20);
    cmp("rsEOI_rot", {5'd0, priority_rotate}, 8'h05);
    ocw(8'hC2, 8'h00);
    cmp("setpri_mask", end_of_interrupt, 8'h00);
    cmp("setpri_rot", {5'd0, priority_rotate}, 8'h02);
    icw1 = 1; tick(); icw1 = 0;
    cmp("icw1_rot", {5'd0, priority_rotate}, 8'h07);

    ocw(8'hA0, 8'h40);
    cmp("rnsEOI_mask", end_of_interrupt, 8'h40);
    cmp("rnsEOI_rot", {5'd0, priority_rotate}, 8'h06);

    ocw(8'h20, 8'h01);
    ocw(8'h20, 8'h02);
    cmp("b2b_second", end_of_interrupt, 8'h02);

    // Reset in the same cycle as a strobe wins.
    idle(); ocw2 = 1; bus = 8'h20; hlis = 8'h08; reset = 1;
    tick();
    cmp("rst_over", end_of_interrupt, 8'h00);
    idle();
    ocw(8'hC6, 8'h00);

    cfg = 1;
`ifdef EOI_CTRL_AUTO_EOI_EN
    ocw(8'h80, 8'h00);
    cmp("arm_set", {7'd0, auto_rotate_mode}, 8'h01);
    idle(); eoas = 1; ack = 8'h04; tick(); idle();
    cmp("aeoi_mask", end_of_interrupt, 8'h04);
    cmp("aeoi_rot", {5'd0, priority_rotate}, 8'h02);
    idle(); ocw2 = 1; bus = 8'h61; eoas = 1; ack = 8'h10; tick(); idle();
    cmp("same_mask", end_of_interrupt, 8'h12);
    cmp("same_rot", {5'd0, priority_rotate}, 8'h04);
    ocw(8'h00, 8'h00);
    cmp("arm_clr", {7'd0, auto_rotate_mode}, 8'h00);
`else
    ocw(8'h80, 8'h00);
    cmp("arm_tied", {7'd0, auto_rotate_mode}, 8'h00);
    idle(); ocw2 = 1; bus = 8'h61; eoas = 1; ack = 8'h10; tick(); idle();
    cmp("same_mask", end_of_interrupt, 8'h02);
    cmp("same_rot", {5'd0, priority_rotate}, 8'h06);
`endif

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      icw1  = ($urandom_range(0, 59) == 0);
      ocw2  = ($urandom_range(0, 1) == 1);
      bus   = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       hlis = 8'h00;
        1:       hlis = 8'($urandom);
        default: hlis = 8'h01 << $urandom_range(0, 7);
      endcase
      cfg  = ($urandom_range(0, 3) != 0);
      eoas = ($urandom_range(0, 2) == 0);
      ack  = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eoi_priority_control_8259a.md
# eoi_priority_control_8259a

Decodes OCW2 commands and automatic-EOI events into the end-of-interrupt clear mask and rotating-priority pointer consumed by the 8259A in-service and priority-resolver logic. It is the command-side driver of the in-service register interface: it produces `end_of_interrupt` pulses and holds `priority_rotate`, while the in-service block reports `highest_level_in_service` back to it. It sits between the bus/control decoder and the in-service/priority blocks, and is fully registered.

## Interface
Parameters: none.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- write_initial_command_word_1  input  1  ICW1 write strobe; re-initialises state
- write_operation_control_word_2  input  1  OCW2 write strobe, one cycle
- internal_data_bus  input  8  OCW2 byte: D7=R, D6=SL, D5=EOI, D2:0=L
- highest_level_in_service  input  8  one-hot highest-priority ISR bit; 0 = ISR empty
- auto_eoi_config  input  1  ICW4 AEOI bit
- end_of_acknowledge_sequence  input  1  pulse on the final INTA cycle
- acknowledge_level  input  8  one-hot level being acknowledged; valid with end_of_acknowledge_sequence
- end_of_interrupt  output  8  one-cycle ISR clear mask
- priority_rotate  output  3  lowest-priority level; 3'b111 = IR0 highest
- auto_rotate_mode  output  1  rotate-on-AEOI enabled

## Operation
- OCW2 decode on `write_operation_control_word_2` using {R,SL,EOI}:
  - 001 non-specific EOI: mask = `highest_level_in_service`
  - 011 specific EOI: mask = 1<<L
  - 101 rotate on non-specific EOI: mask = `highest_level_in_service`; `priority_rotate` = index(highest)
  - 111 rotate on specific EOI: mask = 1<<L; `priority_rotate` = L
  - 110 set priority: `priority_rotate` = L, no mask
  - 100 set rotate-in-AEOI: `auto_rotate_mode` = 1
  - 000 clear rotate-in-AEOI: `auto_rotate_mode` = 0
  - 010 no-op
- index(x): position of lowest set bit of x. When multi-hot, the mask is still passed as-is.
- Non-specific command with `highest_level_in_service` = 0: mask 0; `priority_rotate` unchanged.
- AEOI: when `auto_eoi_config` & `end_of_acknowledge_sequence`, mask |= `acknowledge_level`. If `auto_rotate_mode` and `acknowledge_level` != 0, `priority_rotate` = index(`acknowledge_level`).
- Simultaneous OCW2 and AEOI in the same cycle:
  - masks are ORed
  - OCW2 rotation wins over AEOI rotation
  - `auto_rotate_mode` update takes effect next cycle, not for the concurrent AEOI
- ICW1 write: `priority_rotate` = 3'b111, `auto_rotate_mode` = 0, `end_of_interrupt` = 0. Overrides any same-cycle OCW2/AEOI.
- Bits D4:D3 of OCW2 are ignored (the bus decoder already qualified them).

## Timing
- Reset values: `end_of_interrupt` = 8'h00, `priority_rotate` = 3'b111, `auto_rotate_mode` = 0.
- All outputs are registered. Latency is 1 cycle from strobe to output.
- `end_of_interrupt` is high for exactly one cycle per event and returns to 0 the next cycle unless a new event occurs.
- Back-to-back OCW2 writes on consecutive cycles each produce their own pulse, with no bubble.
- `highest_level_in_service` is sampled in the strobe cycle, not later.
- `priority_rotate` holds its value until the next rotation command, AEOI rotation, ICW1, or reset.
- Reset asserted mid-pulse clears outputs on the next edge. Reset overrides all strobes.

## Configuration
- `EOI_CTRL_AUTO_EOI_EN` defined: AEOI path and rotate-in-AEOI commands behave as above.
- Not defined:
  - `auto_eoi_config`, `end_of_acknowledge_sequence` and `acknowledge_level` are ignored.
  - Commands 100/000 are no-ops.
  - `auto_rotate_mode` is tied to 0.

## Test plan
- Reset then idle -> `end_of_interrupt` = 00, `priority_rotate` = 111, `auto_rotate_mode` = 0 for 10 cycles.
- `highest_level_in_service` = 8'h08, OCW2 = 8'h20 -> `end_of_interrupt` = 08 for one cycle, then 00; `priority_rotate` stays 111. Repeat with highest = 00 -> no pulse.
- OCW2 = 8'hE5 -> `end_of_interrupt` = 20, `priority_rotate` = 101. Then OCW2 = 8'hC2 -> no pulse, `priority_rotate` = 010. Then ICW1 -> `priority_rotate` = 111.
- OCW2 = 8'hA0 with highest = 8'h40 -> `end_of_interrupt` = 40, `priority_rotate` = 110.
- With macro defined: auto_eoi_config = 1, OCW2 = 8'h80 -> `auto_rotate_mode` = 1. Ack with level 8'h04 -> `end_of_interrupt` = 04, `priority_rotate` = 010. OCW2 = 8'h00 -> `auto_rotate_mode` = 0.
- Same cycle: OCW2 = 8'h61 (specific EOI, L=1) plus AEOI ack level 8'h10 with auto_rotate_mode = 1 -> `end_of_interrupt` = 12, `priority_rotate` = 100. Without macro, same stimulus -> `end_of_interrupt` = 02, `priority_rotate` unchanged.
